spi_burst_dcd: RTL and testbench

// - Next-generation SPI byte-stream instruction decoder: header byte, then 1..MAX_BURST data bytes per frame.
// - Supports single and auto-increment burst access to the register bank.
// - Parametrised address width.
// - Adds frame awareness via cs_active and a sticky burst-overrun flag.
// - Sits between the SPI slave shifter and the PWM register bank, in place of the single-access decoder.

---
 rtl/spi_dcd_pkg.sv | 20 ++
 rtl/spi_dcd_addr_ctr.sv | 59 +++++
 rtl/spi_burst_dcd.sv | 171 +++++++++++++++++
 tb/tb_spi_burst_dcd.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_dcd_pkg.sv
// Shared definitions for the SPI burst instruction decoder: FSM state
// encoding and header-byte field positions.
package spi_dcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HDR   = 2'd1,
    ST_DATA  = 2'd2,
    ST_DRAIN = 2'd3
  } dcd_state_e;

  localparam int HDR_RW  = 7;
  localparam int HDR_INC = 6;

  // Extract the op/inc pair of a header byte as {is_write, auto_inc}.
  function automatic logic [1:0] hdr_flags(input logic [7:0] hdr);
    return {hdr[HDR_RW], hdr[HDR_INC]};
  endfunction

endpackage

// File: rtl/spi_dcd_addr_ctr.sv
// Loadable ADDR_W-bit address counter with optional auto-increment.
// On overflow it either wraps to zero or holds at the top address.
module spi_dcd_addr_ctr #(
  parameter int ADDR_W  = 6,
  parameter int WRAP_EN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] load_val_i,
  input  logic              en_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] cnt_o,
  output logic [ADDR_W-1:0] nxt_o
);

  localparam logic [ADDR_W-1:0] ADDR_MAX  = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};

  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] cnt_d;
  logic [ADDR_W-1:0] step_s;

  always_comb begin
    step_s = cnt_q;
    if (!inc_i) begin
      step_s = cnt_q;
    end else if (cnt_q != ADDR_MAX) begin
      step_s = cnt_q + ADDR_W'(1);
    end else if (WRAP_EN != 0) begin
      step_s = ADDR_ZERO;
    end else begin
      step_s = ADDR_MAX;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i) begin
      cnt_d = step_s;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= ADDR_ZERO;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign nxt_o = step_s;

endmodule

// File: rtl/spi_burst_dcd.sv
// SPI byte-stream decoder: one header byte then up to MAX_BURST data bytes,
// driving single or auto-incrementing burst accesses into the register bank.
module spi_burst_dcd
  import spi_dcd_pkg::*;
#(
  parameter int ADDR_W    = 6,
  parameter int MAX_BURST = 16,
  parameter int WRAP_EN   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs_active,
  input  logic              byte_sync,
  input  logic [7:0]        data_in,
  output logic [7:0]        data_out,
  output logic              read,
  output logic              write,
  output logic [ADDR_W-1:0] addr,
  input  logic [7:0]        data_read,
  output logic [7:0]        data_write,
  output logic              burst_err
);

  localparam int              CNT_W   = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

  dcd_state_e        state_q, state_d;
  logic              cs_prev_q;
  logic              op_wr_q, op_wr_d;
  logic              inc_q, inc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              burst_err_q, burst_err_d;
  logic              read_q, read_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        data_write_q, data_write_d;

  logic              cs_rise_s;
  logic              ctr_load_s;
  logic              ctr_en_s;
  logic [ADDR_W-1:0] cur_s;
  logic [ADDR_W-1:0] cur_nxt_s;
  logic [1:0]        hdr_flags_s;

  assign cs_rise_s   = cs_active & ~cs_prev_q;
  assign hdr_flags_s = hdr_flags(data_in);

  spi_dcd_addr_ctr #(
    .ADDR_W  (ADDR_W),
    .WRAP_EN (WRAP_EN)
  ) u_addr_ctr (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (ctr_load_s),
    .load_val_i (data_in[ADDR_W-1:0]),
    .en_i       (ctr_en_s),
    .inc_i      (inc_q),
    .cnt_o      (cur_s),
    .nxt_o      (cur_nxt_s)
  );

  always_comb begin
    state_d      = state_q;
    op_wr_d      = op_wr_q;
    inc_d        = inc_q;
    cnt_d        = cnt_q;
    burst_err_d  = burst_err_q;
    read_d       = read_q;
    write_d      = 1'b0;
    addr_d       = addr_q;
    data_write_d = data_write_q;
    ctr_load_s   = 1'b0;
    ctr_en_s     = 1'b0;

    // Frame end wins over any byte arriving in the same cycle.
    if (!cs_active) begin
      state_d = ST_IDLE;
      read_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cs_rise_s) begin
            state_d = ST_HDR;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_HDR: begin
          if (byte_sync) begin
            op_wr_d     = hdr_flags_s[1];
            inc_d       = hdr_flags_s[0];
            ctr_load_s  = 1'b1;
            cnt_d       = {CNT_W{1'b0}};
            burst_err_d = 1'b0;
            read_d      = ~hdr_flags_s[1];
            if (!hdr_flags_s[1]) begin
              addr_d = data_in[ADDR_W-1:0];
            end else begin
              addr_d = addr_q;
            end
            state_d = ST_DATA;
          end else begin
            state_d = ST_HDR;
          end
        end
        ST_DATA: begin
          if (!byte_sync) begin
            state_d = ST_DATA;
          end else if (cnt_q == CNT_MAX) begin
            state_d     = ST_DRAIN;
            burst_err_d = 1'b1;
            read_d      = 1'b0;
          end else begin
            ctr_en_s = 1'b1;
            cnt_d    = cnt_q + CNT_W'(1);
            // Writes target the current address; reads pre-fetch the next one.
            if (op_wr_q) begin
              write_d      = 1'b1;
              addr_d       = cur_s;
              data_write_d = data_in;
            end else begin
              addr_d = cur_nxt_s;
            end
          end
        end
        ST_DRAIN: begin
          state_d = ST_DRAIN;
        end
        default: begin
          state_d = ST_IDLE;
          read_d  = 1'b0;
        end
      endcase
    end
  end

  // Decoder state and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cs_prev_q    <= 1'b1;
      op_wr_q      <= 1'b0;
      inc_q        <= 1'b0;
      cnt_q        <= {CNT_W{1'b0}};
      burst_err_q  <= 1'b0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      addr_q       <= {ADDR_W{1'b0}};
      data_write_q <= 8'h00;
    end else begin
      state_q      <= state_d;
      cs_prev_q    <= cs_active;
      op_wr_q      <= op_wr_d;
      inc_q        <= inc_d;
      cnt_q        <= cnt_d;
      burst_err_q  <= burst_err_d;
      read_q       <= read_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      data_write_q <= data_write_d;
    end
  end

  assign read       = read_q;
  assign write      = write_q;
  assign addr       = addr_q;
  assign data_write = data_write_q;
  assign burst_err  = burst_err_q;
  assign data_out   = read_q ? data_read : 8'h00;

endmodule

// File: tb/tb_spi_burst_dcd.sv
// Directed bench for spi_burst_dcd: a per-cycle vector table on the default
// configuration plus hand sequences for saturation, overrun, abort and reset.
module tb_spi_burst_dcd;

  logic       clk;
  logic       rst_n;
  logic       cs_active;
  logic       byte_sync;
  logic [7:0] data_in;
  logic [7:0] bank [64];

  logic [7:0] m_dout, m_dr, m_dw;
  logic       m_read, m_write, m_berr;
  logic [5:0] m_addr;
  logic [7:0] s_dout, s_dr, s_dw;
  logic       s_read, s_write, s_berr;
  logic [5:0] s_addr;
  logic [7:0] o_dout, o_dr, o_dw;
  logic       o_read, o_write, o_berr;
  logic [5:0] o_addr;

  int n_chk;
  int n_pass;
  int o_wcount;

  assign m_dr = bank[m_addr];
  assign s_dr = bank[s_addr];
  assign o_dr = bank[o_addr];

  spi_burst_dcd #(.ADDR_W(6), .MAX_BURST(16), .WRAP_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .cs_active(cs_active), .byte_sync(byte_sync),
    .data_in(data_in), .data_out(m_dout), .read(m_read), .write(m_write),
    .addr(m_addr), .data_read(m_dr), .data_write(m_dw), .burst_err(m_berr));

  spi_burst_dcd #(.ADDR_W(6), .MAX_BURST(16), .WRAP_EN(0)) dut_sat (
    .clk(clk), .rst_n(rst_n), .cs_active(cs_active), .byte_sync(byte_sync),
    .data_in(data_in), .data_out(s_dout), .read(s_read), .write(s_write),
    .addr(s_addr), .data_read(s_dr), .data_write(s_dw), .burst_err(s_berr));

  spi_burst_dcd #(.ADDR_W(6), .MAX_BURST(2), .WRAP_EN(1)) dut_ovr (
    .clk(clk), .rst_n(rst_n), .cs_active(cs_active), .byte_sync(byte_sync),
    .data_in(data_in), .data_out(o_dout), .read(o_read), .write(o_write),
    .addr(o_addr), .data_read(o_dr), .data_write(o_dw), .burst_err(o_berr));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (o_write) o_wcount <= o_wcount + 1;
  end

  typedef struct {
    logic       cs;
    logic       bs;
    logic [7:0] din;
    logic       ew;
    logic       er;
    logic       eb;
    logic [7:0] edo;
    logic       ck;
    logic [5:0] ea;
    logic [7:0] edw;
  } vec_t;

  vec_t tv[$];

  task automatic v(input logic cs, input logic bs, input logic [7:0] din,
                   input logic ew, input logic er, input logic eb, input logic [7:0] edo,
                   input logic ck, input logic [5:0] ea, input logic [7:0] edw);
    vec_t t;
    t.cs = cs; t.bs = bs; t.din = din; t.ew = ew; t.er = er; t.eb = eb;
    t.edo = edo; t.ck = ck; t.ea = ea; t.edw = edw;
    tv.push_back(t);
  endtask

  task automatic step(input logic cs, input logic bs, input logic [7:0] d);
    @(negedge clk);
    cs_active = cs;
    byte_sync = bs;
    data_in   = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  initial begin
    logic [24:0] act_v, exp_v;
    int          w0;

    n_chk = 0; n_pass = 0; o_wcount = 0;
    for (int i = 0; i < 64; i++) bank[i] = 8'hA0 + 8'(i);
    rst_n = 1'b0; cs_active = 1'b0; byte_sync = 1'b0; data_in = 8'h00;

    // cs byte  din    w  r  b  dout  ck addr   dw
    v(0, 0, 8'h00, 0, 0, 0, 8'h00, 1, 6'd0,  8'h00);
    v(1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 6'd0,  8'h00);
    v(1, 1, 8'h85, 0, 0, 0, 8'h00, 0, 6'd0,  8'h00);
    v(1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 6'd0,  8'h00);
    v(1, 1, 8'h3C, 1, 0, 0, 8'h00, 1, 6'd5,  8'h3C);
    v(1, 0, 8'h00, 0, 0, 0, 8'h00, 1, 6'd5,  8'h3C);
    v(0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 6'd0,  8'h00);
    v(1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 6'd0,  8'h00);
    v(1, 1, 8'hC2, 0, 0, 0, 8'h00, 0, 6'd0,  8'h00);
    v(1, 1, 8'h11, 1, 0, 0, 8'h00, 1, 6'd2,  8'h11);
    v(1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 6'd0,  8'h00);
    v(1, 1, 8'h22, 1, 0, 0, 8'h00, 1, 6'd3,  8'h22);
    v(1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 6'd0,  8'h00);
    v(1, 1, 8'h33, 1, 0, 0, 8'h00, 1, 6'd4,  8'h33);
    v(1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 6'd0,  8'h00);
    v(0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 6'd0,  8'h00);
    v(1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 6'd0,  8'h00);
    v(1, 1, 8'h40, 0, 1, 0, 8'hA0, 1, 6'd0,  8'h33);
    v(1, 0, 8'h00, 0, 1, 0, 8'hA0, 1, 6'd0,  8'h33);
    v(1, 1, 8'h00, 0, 1, 0, 8'hA1, 1, 6'd1,  8'h33);
    v(1, 0, 8'h00, 0, 1, 0, 8'hA1, 1, 6'd1,  8'h33);
    v(1, 1, 8'h00, 0, 1, 0, 8'hA2, 1, 6'd2,  8'h33);
    v(1, 1, 8'h00, 0, 1, 0, 8'hA3, 1, 6'd3,  8'h33);
    v(0, 0, 8'h00, 0, 0, 0, 8'h00, 1, 6'd3,  8'h33);
    v(1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 6'd0,  8'h00);
    v(1, 1, 8'h07, 0, 1, 0, 8'hA7, 1, 6'd7,  8'h33);
    v(1, 1, 8'h00, 0, 1, 0, 8'hA7, 1, 6'd7,  8'h33);
    v(1, 1, 8'h00, 0, 1, 0, 8'hA7, 1, 6'd7,  8'h33);
    v(0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 6'd0,  8'h00);
    v(1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 6'd0,  8'h00);
    v(1, 1, 8'h8A, 0, 0, 0, 8'h00, 0, 6'd0,  8'h00);
    v(1, 1, 8'h5A, 1, 0, 0, 8'h00, 1, 6'd10, 8'h5A);
    v(1, 0, 8'h00, 0, 0, 0, 8'h00, 1, 6'd10, 8'h5A);
    v(1, 1, 8'h5B, 1, 0, 0, 8'h00, 1, 6'd10, 8'h5B);
    v(0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 6'd0,  8'h00);
    v(1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 6'd0,  8'h00);
    v(1, 1, 8'hFF, 0, 0, 0, 8'h00, 0, 6'd0,  8'h00);
    v(1, 1, 8'hAA, 1, 0, 0, 8'h00, 1, 6'd63, 8'hAA);
    v(1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 6'd0,  8'h00);
    v(1, 1, 8'hBB, 1, 0, 0, 8'h00, 1, 6'd0,  8'hBB);
    v(0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 6'd0,  8'h00);
    v(0, 1, 8'h85, 0, 0, 0, 8'h00, 1, 6'd0,  8'hBB);
    v(0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 6'd0,  8'h00);
    v(1, 1, 8'h85, 0, 0, 0, 8'h00, 0, 6'd0,  8'h00);
    v(1, 1, 8'h3C, 0, 1, 0, 8'hDC, 1, 6'd60, 8'hBB);
    v(0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 6'd0,  8'h00);

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tv[i]) begin
      step(tv[i].cs, tv[i].bs, tv[i].din);
      act_v = {m_write, m_read, m_berr, m_dout,
               tv[i].ck ? m_addr : 6'd0, tv[i].ck ? m_dw : 8'h00};
      exp_v = {tv[i].ew, tv[i].er, tv[i].eb, tv[i].edo,
               tv[i].ck ? tv[i].ea : 6'd0, tv[i].ck ? tv[i].edw : 8'h00};
      chk($sformatf("vec%0d", i), 32'(act_v), 32'(exp_v));
    end

    // Saturating configuration: both writes land on the top address.
    step(1, 0, 8'h00);
    step(1, 1, 8'hFF);
    step(1, 1, 8'hAA);
    chk("sat_wr1", {s_write, 2'b00, s_addr, s_dw}, {1'b1, 2'b00, 6'd63, 8'hAA});
    step(1, 0, 8'h00);
    step(1, 1, 8'hBB);
    chk("sat_wr2", {s_write, 2'b00, s_addr, s_dw}, {1'b1, 2'b00, 6'd63, 8'hBB});
    chk("wrap_wr2", {m_write, 2'b00, m_addr, m_dw}, {1'b1, 2'b00, 6'd0, 8'hBB});
    step(0, 0, 8'h00);

    // Overrun with MAX_BURST=2.
    step(1, 0, 8'h00);
    step(1, 1, 8'hC0);
    chk("ovr_hdr_clr", 32'(o_berr), 32'd0);
    w0 = o_wcount;
    step(1, 1, 8'h01);
    chk("ovr_wr1", {o_write, 2'b00, o_addr, o_dw}, {1'b1, 2'b00, 6'd0, 8'h01});
    step(1, 0, 8'h00);
    step(1, 1, 8'h02);
    chk("ovr_wr2", {o_write, 2'b00, o_addr, o_dw}, {1'b1, 2'b00, 6'd1, 8'h02});
    step(1, 0, 8'h00);
    step(1, 1, 8'h03);
    chk("ovr_drop3", {o_write, o_berr}, {1'b0, 1'b1});
    step(1, 0, 8'h00);
    step(1, 1, 8'h04);
    chk("ovr_drop4", {o_write, o_berr}, {1'b0, 1'b1});
    chk("ovr_main_noerr", 32'(m_berr), 32'd0);
    step(0, 0, 8'h00);
    chk("ovr_sticky", 32'(o_berr), 32'd1);
    chk("ovr_wcount", 32'(o_wcount - w0), 32'd2);
    step(1, 0, 8'h00);
    step(1, 1, 8'h85);
    chk("ovr_hdr_clears", 32'(o_berr), 32'd0);
    step(0, 0, 8'h00);

    // Abort: cs drops on the data byte of a write frame.
    step(1, 0, 8'h00);
    step(1, 1, 8'h85);
    step(0, 1, 8'h3C);
    chk("abort_wr_same", 32'(m_write), 32'd0);
    step(0, 0, 8'h00);
    chk("abort_wr_after", 32'(m_write), 32'd0);

    // Abort of a read burst: read and data_out drop with cs.
    step(1, 0, 8'h00);
    step(1, 1, 8'h41);
    chk("abort_rd_hdr", {m_read, m_dout}, {1'b1, 8'hA1});
    step(1, 1, 8'h00);
    step(0, 0, 8'h00);
    chk("abort_rd_drop", {m_read, m_dout}, {1'b0, 8'h00});
    step(1, 0, 8'h00);
    step(1, 1, 8'h85);
    step(1, 1, 8'h3C);
    chk("post_abort_wr", {m_write, 2'b00, m_addr, m_dw}, {1'b1, 2'b00, 6'd5, 8'h3C});
    step(0, 0, 8'h00);

    // Async reset mid read burst, then a frame with cs held high is ignored.
    step(1, 0, 8'h00);
    step(1, 1, 8'h43);
    step(1, 1, 8'h00);
    chk("pre_rst_rd", {m_read, m_addr}, {1'b1, 6'd4});
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async", {m_write, m_read, m_berr, m_dout, m_addr, m_dw},
        {1'b0, 1'b0, 1'b0, 8'h00, 6'd0, 8'h00});
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 1, 8'h85);
    step(1, 1, 8'h3C);
    chk("rst_no_rise", {m_write, m_read}, {1'b0, 1'b0});
    step(0, 0, 8'h00);
    step(1, 0, 8'h00);
    step(1, 1, 8'hC2);
    step(1, 1, 8'h77);
    chk("post_rst_wr", {m_write, 2'b00, m_addr, m_dw}, {1'b1, 2'b00, 6'd2, 8'h77});
    step(0, 0, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
